// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter turning two level-held request ports into SDRAM controller rd/we strobes.
// Ack comes GUARD_CYCLES+1 cycles after the grant at the earliest; requests stay pending while busy or mem_ready is low.
module sdram_port_arbiter #(
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [24:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic [1:0]  a_wtbt,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [24:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [1:0]  b_wtbt,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_wtbt,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [15:0] mem_dout,
  output logic        busy,
  output logic        timeout
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] din;
    logic [1:0]  wtbt;
  } mem_cmd_t;

  typedef enum logic [1:0] {IDLE, GUARD, WAIT, RECOVER} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  // 1 = port B; it also identifies the port being served while busy
  logic          last_grant, last_grant_nxt;
  mem_cmd_t      cmd, cmd_nxt;
  logic          rd_nxt, we_nxt, a_ack_nxt, b_ack_nxt, timeout_nxt;
  logic [15:0]   a_rdata_nxt, b_rdata_nxt, done_data;
  logic          pick_b, sel_we;

  assign mem_addr = cmd.addr;
  assign mem_din  = cmd.din;
  assign mem_wtbt = cmd.wtbt;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    cmd_nxt        = cmd;
    rd_nxt         = mem_rd;
    we_nxt         = mem_we;
    a_ack_nxt      = 1'b0;
    b_ack_nxt      = 1'b0;
    timeout_nxt    = 1'b0;
    a_rdata_nxt    = a_rdata;
    b_rdata_nxt    = b_rdata;
    done_data      = 16'hFFFF;
    pick_b         = 1'b0;
    sel_we         = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_ready && (a_req || b_req)) begin
          pick_b         = b_req && (!a_req || !last_grant);
          sel_we         = pick_b ? b_we : a_we;
          cmd_nxt        = pick_b ? {b_addr, b_wdata, b_wtbt} : {a_addr, a_wdata, a_wtbt};
          rd_nxt         = !sel_we;
          we_nxt         = sel_we;
          last_grant_nxt = pick_b;
          cnt_nxt        = GUARD_LOAD;
          state_nxt      = GUARD;
        end
      end
      // Hold the strobe long enough for the controller's registered ready to fall.
      GUARD: begin
        if (cnt == '0) begin
          state_nxt = WAIT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (mem_ready || cnt == TO_LAST) begin
          done_data   = mem_ready ? mem_dout : 16'hFFFF;
          timeout_nxt = !mem_ready;
          rd_nxt      = 1'b0;
          we_nxt      = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = RECOVER;
          if (last_grant) begin
            b_ack_nxt = 1'b1;
            if (mem_rd) b_rdata_nxt = done_data;
          end else begin
            a_ack_nxt = 1'b1;
            if (mem_rd) a_rdata_nxt = done_data;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      cmd        <= '0;
      mem_rd     <= 1'b0;
      mem_we     <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      timeout    <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      cmd        <= cmd_nxt;
      mem_rd     <= rd_nxt;
      mem_we     <= we_nxt;
      a_ack      <= a_ack_nxt;
      b_ack      <= b_ack_nxt;
      timeout    <= timeout_nxt;
      a_rdata    <= a_rdata_nxt;
      b_rdata    <= b_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level model driven by a scripted controller ready/dout waveform.
module tb_sdram_port_arbiter;

  localparam int G = 2;
  localparam int T = 64;
  localparam int STUCK = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [24:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic [1:0] a_wtbt = '0, b_wtbt = '0;
  logic a_ack, b_ack, mem_we, mem_rd, busy, timeout;
  logic [15:0] a_rdata, b_rdata, mem_din;
  logic [24:0] mem_addr;
  logic [1:0] mem_wtbt;
  logic mem_ready = 1'b1;
  logic [15:0] mem_dout = '0;

  sdram_port_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_wtbt(a_wtbt),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wtbt(b_wtbt),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wtbt(mem_wtbt), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .mem_dout(mem_dout), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state; cycle numbers count clock edges seen by step().
  int cyc = 0, g, ack_edge, free_edge, low_start, low_end, rd_hi = 0;
  int next_lat = -1, ovr_dout = -1;
  bit active, last_port, cur_port, cur_we, to_exp, auto_req = 0;
  bit pend, pend_port, pend_we;
  logic [42:0] pend_cmd, exp_cmd;
  logic [15:0] dval, exp_ra, exp_rb;

  function automatic logic [15:0] memval(input logic [24:0] ad);
    logic [15:0] w;
    w = 16'((ad >> 1) * 40503) ^ 16'h5A5A;
    return ad[0] ? {w[7:0], w[15:8]} : w;
  endfunction

  function automatic bit rdy_at(input int e);
    return !(e >= low_start && e <= low_end);
  endfunction

  task automatic model_init();
    active = 0; free_edge = 0; last_port = 1; low_start = 1; low_end = 0;
    exp_cmd = '0; exp_ra = '0; exp_rb = '0; pend = 0;
  endtask

  task automatic start_txn();
    int lat, r;
    active = 1; g = cyc; cur_port = pend_port; cur_we = pend_we;
    last_port = pend_port; exp_cmd = pend_cmd;
    if (next_lat >= 0) lat = next_lat;
    else begin
      r = int'($urandom_range(0, 11));
      lat = (r <= 8) ? r : (r == 9) ? G + T - 2 : (r == 10) ? G + T - 1 : STUCK;
    end
    low_start = g + 2;
    low_end = (lat >= STUCK) ? g + G + T + int'($urandom_range(0, 3)) : g + 1 + lat;
    if (low_end < g + G + 1) begin ack_edge = g + G + 1; to_exp = 0; end
    else if (low_end + 1 <= g + G + T) begin ack_edge = low_end + 1; to_exp = 0; end
    else begin ack_edge = g + G + T; to_exp = 1; end
    dval = (ovr_dout >= 0) ? 16'(ovr_dout) : memval(pend_cmd[42:18]);
    free_edge = ack_edge + 2;
    next_lat = -1; ovr_dout = -1;
  endtask

  task automatic new_req(input bit p);
    if (p) begin
      b_req = 1; b_we = 1'($urandom); b_addr = 25'($urandom); b_wdata = 16'($urandom); b_wtbt = 2'($urandom);
    end else begin
      a_req = 1; a_we = 1'($urandom); a_addr = 25'($urandom); a_wdata = 16'($urandom); a_wtbt = 2'($urandom);
    end
  endtask

  task automatic agent(input bit p, input logic seen);
    if (seen === 1'b1 || (p ? !b_req : !a_req)) begin
      if ($urandom_range(0, 2) == 0) begin
        if (p) b_req = 0; else a_req = 0;
      end else new_req(p);
    end
  endtask

  task automatic set_req(input bit p, input logic we, input logic [24:0] ad,
                         input logic [15:0] wd, input logic [1:0] bt);
    if (p) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; b_wtbt = bt; end
    else begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; a_wtbt = bt; end
  endtask

  task automatic step();
    logic [5:0] exp_ctl;
    bit in_txn, at_ack;
    pend = 0;
    if (cyc + 1 >= free_edge && rdy_at(cyc + 1) && (a_req || b_req)) begin
      pend = 1;
      pend_port = (a_req && b_req) ? !last_port : b_req;
      pend_we = pend_port ? b_we : a_we;
      pend_cmd = pend_port ? {b_addr, b_wdata, b_wtbt} : {a_addr, a_wdata, a_wtbt};
    end
    mem_ready = rdy_at(cyc + 1);
    mem_dout = (active && cyc + 1 == ack_edge) ? dval : 16'($urandom);
    @(posedge clk);
    #1;
    cyc++;
    if (pend) start_txn();
    in_txn = active && cyc < ack_edge;
    at_ack = active && cyc == ack_edge;
    if (at_ack && !cur_we) begin
      if (cur_port) exp_rb = to_exp ? 16'hFFFF : dval;
      else exp_ra = to_exp ? 16'hFFFF : dval;
    end
    exp_ctl = {in_txn && !cur_we, in_txn && cur_we, at_ack && !cur_port,
               at_ack && cur_port, at_ack && to_exp, active};
    check_eq("ctl rd/we/aack/back/to/busy", 64'({mem_rd, mem_we, a_ack, b_ack, timeout, busy}), 64'(exp_ctl));
    check_eq("mem cmd", 64'({mem_addr, mem_din, mem_wtbt}), 64'(exp_cmd));
    check_eq("rdata a/b", 64'({a_rdata, b_rdata}), 64'({exp_ra, exp_rb}));
    if (mem_rd) rd_hi++;
    if (at_ack) active = 0;
    if (auto_req) begin agent(0, a_ack); agent(1, b_ack); end
  endtask

  task automatic wait_ack(input bit p, input int budget, output int n);
    n = 0;
    do begin step(); n++; end while (!(p ? b_ack : a_ack) && n < budget);
    check_eq("ack seen", 64'(p ? b_ack : a_ack), 64'(1));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] w;
    model_init();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset state", 64'({mem_rd, mem_we, a_ack, b_ack, timeout, busy, a_rdata, b_rdata, mem_addr}), 64'(0));
    reset = 0;

    // read with ready low for 6 cycles: strobe high 8 cycles
    ovr_dout = 'h1234; next_lat = 6; rd_hi = 0;
    set_req(0, 0, 25'h000100, 16'h0, 2'b00);
    wait_ack(0, 100, n);
    check_eq("t1 rd len", 64'(rd_hi), 64'(8));
    check_eq("t1 rdata", 64'(a_rdata), 64'(16'h1234));
    a_req = 0; step();

    set_req(0, 1, 25'h0000A0, 16'hBEEF, 2'b11); next_lat = 3;
    wait_ack(0, 100, n);
    check_eq("t2 din/wtbt", 64'({mem_din, mem_wtbt}), 64'({16'hBEEF, 2'b11}));
    check_eq("t2 rdata kept", 64'(a_rdata), 64'(16'h1234));
    a_req = 0; step();

    // same-word hits with ready held high
    set_req(0, 0, 25'h000200, 16'h0, 2'b00); next_lat = 0;
    wait_ack(0, 100, n);
    check_eq("t4 lat0", 64'(n), 64'(G + 2));
    check_eq("t4 rd0", 64'(a_rdata), 64'(memval(25'h000200)));
    step();
    set_req(0, 0, 25'h000201, 16'h0, 2'b00); next_lat = 0;
    wait_ack(0, 100, n);
    w = memval(25'h000200);
    check_eq("t4 lat1", 64'(n), 64'(G + 2));
    check_eq("t4 swap", 64'(a_rdata), 64'({w[7:0], w[15:8]}));
    a_req = 0; step();

    // ready stuck low: watchdog completion, then a normal request
    set_req(1, 0, 25'h0ABCDE, 16'h0, 2'b00); next_lat = STUCK;
    wait_ack(1, 100, n);
    check_eq("t5 lat", 64'(n), 64'(G + T + 1));
    check_eq("t5 timeout", 64'(timeout), 64'(1));
    check_eq("t5 rdata", 64'(b_rdata), 64'(16'hFFFF));
    b_req = 0; step();
    set_req(0, 0, 25'h000311, 16'h0, 2'b00); next_lat = 2;
    wait_ack(0, 100, n);
    check_eq("t5 next", 64'(a_rdata), 64'(memval(25'h000311)));
    a_req = 0; step();

    // reset during WAIT
    set_req(0, 0, 25'h003000, 16'h0, 2'b00); next_lat = 20;
    repeat (5) step();
    check_eq("t6 in wait", 64'({mem_rd, busy}), 64'(2'b11));
    #3 reset = 1;
    #1;
    check_eq("t6 async drop", 64'({mem_rd, mem_we, busy, a_ack}), 64'(0));
    repeat (2) begin
      @(posedge clk);
      #1;
      check_eq("t6 in reset", 64'({a_ack, b_ack, mem_rd, busy}), 64'(0));
    end
    set_req(1, 0, 25'h004000, 16'h0, 2'b00);
    model_init();
    reset = 0;

    // both held: A first after reset, then alternate
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin step(); n++; end while (!(a_ack || b_ack) && n < 100);
      check_eq("t3 rr order", 64'({a_ack, b_ack}), (k % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
    end

    auto_req = 1;
    repeat (3000) step();
    auto_req = 0; a_req = 0; b_req = 0;
    repeat (80) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
